// File: rtl/tx_iq_pkg.sv
// Shared types and helpers for the transmit I/Q output buffer.
package tx_iq_pkg;

    localparam int IQ_W    = 16;
    localparam int UCNT_W  = 16;
    localparam int TAIL_W  = 8;

    // Output sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        TAIL   = 2'd3
    } tx_state_e;

    // One FIFO slot: an I/Q pair plus the end-of-packet marker
    typedef struct packed {
        logic [IQ_W-1:0] i;
        logic [IQ_W-1:0] q;
        logic            last;
    } iq_entry_t;

    // Saturating increment for the per-packet underflow counter
    function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] v);
        return (v == {UCNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/tx_iq_fifo.sv
// Synchronous FIFO of iq_entry_t with occupancy and a count of stored
// last-marked entries, so the parent can tell a short packet is complete.
module tx_iq_fifo
    import tx_iq_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                push_i,
    input  iq_entry_t           wdata_i,
    input  logic                pop_i,
    output iq_entry_t           rdata_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [DEPTH_LOG2:0] count_o,
    output logic [DEPTH_LOG2:0] last_cnt_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);

    iq_entry_t mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [DEPTH_LOG2:0]   last_cnt_q, last_cnt_d;
    logic                  do_push;
    logic                  do_pop;

    // Full is taken from the registered count only: a same-cycle pop never frees a slot for a push
    assign full_o     = (count_q == DEPTH_C);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign last_cnt_o = last_cnt_q;
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;

    // Fall-through read so a strobe can pop and load the output register in the same cycle
    assign rdata_o = mem[rd_ptr_q];

    // Storage write; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer, occupancy and last-count next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        last_cnt_d = last_cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        case ({do_push && wdata_i.last, do_pop && rdata_o.last})
            2'b10:   last_cnt_d = last_cnt_q + 1'b1;
            2'b01:   last_cnt_d = last_cnt_q - 1'b1;
            default: last_cnt_d = last_cnt_q;
        endcase
    end

    // Pointer and counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_cnt_q <= last_cnt_d;
        end
    end

endmodule

// File: rtl/tx_iq_out_buffer.sv
// DAC-side output buffer: queues scaled I/Q pairs, primes, then releases one
// sample per DAC strobe, zero-fills underflows and appends a zero tail.
module tx_iq_out_buffer
    import tx_iq_pkg::*;
#(
    parameter int DEPTH_LOG2  = 4,
    parameter int START_LEVEL = 8,
    parameter int TAIL_LEN    = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [IQ_W-1:0]   in_i,
    input  logic [IQ_W-1:0]   in_q,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              dac_strobe,
    output logic [2*IQ_W-1:0] dac_iq,
    output logic              dac_valid,
    output logic              tx_active,
    output logic              underflow,
    output logic [UCNT_W-1:0] underflow_cnt,
    output logic              tx_done
);

    localparam logic [DEPTH_LOG2:0] START_C = (DEPTH_LOG2 + 1)'(START_LEVEL);
    localparam logic [TAIL_W-1:0]   TAIL_C  = TAIL_W'(TAIL_LEN);

    tx_state_e           state_q, state_d;
    logic [TAIL_W-1:0]   tail_cnt_q, tail_cnt_d;
    logic [2*IQ_W-1:0]   dac_iq_q, dac_iq_d;
    logic                dac_valid_q, dac_valid_d;
    logic                underflow_q, underflow_d;
    logic [UCNT_W-1:0]   ucnt_q, ucnt_d;
    logic                tx_done_q, tx_done_d;
    logic                tx_active_q, tx_active_d;

    iq_entry_t           wr_entry;
    iq_entry_t           rd_entry;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DEPTH_LOG2:0] fifo_count;
    logic [DEPTH_LOG2:0] fifo_last_cnt;

    assign wr_entry = '{i: in_i, q: in_q, last: in_last};

    tx_iq_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push_i     (in_valid),
        .wdata_i    (wr_entry),
        .pop_i      (fifo_pop),
        .rdata_o    (rd_entry),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count),
        .last_cnt_o (fifo_last_cnt)
    );

    // Ready depends only on registered occupancy, so it reads 1 throughout reset
    assign in_ready = !fifo_full;

    // Sequencer and output next-state
    always_comb begin
        state_d     = state_q;
        tail_cnt_d  = tail_cnt_q;
        dac_iq_d    = dac_iq_q;
        dac_valid_d = dac_valid_q;
        underflow_d = 1'b0;
        ucnt_d      = ucnt_q;
        tx_done_d   = 1'b0;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                dac_iq_d    = '0;
                dac_valid_d = 1'b0;
                if (!fifo_empty) begin
                    state_d = PRIME;
                    ucnt_d  = '0;
                end
            end
            PRIME: begin
                dac_iq_d    = '0;
                dac_valid_d = 1'b0;
                // A complete short packet must not wait for the start level
                if (fifo_count >= START_C || fifo_last_cnt != '0) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (dac_strobe) begin
                    if (fifo_empty) begin
                        dac_iq_d    = '0;
                        dac_valid_d = 1'b0;
                        underflow_d = 1'b1;
                        ucnt_d      = sat_inc(ucnt_q);
                    end else begin
                        fifo_pop    = 1'b1;
                        dac_iq_d    = {rd_entry.i, rd_entry.q};
                        dac_valid_d = 1'b1;
                        if (rd_entry.last) begin
                            if (TAIL_C == '0) begin
                                state_d   = IDLE;
                                tx_done_d = 1'b1;
                            end else begin
                                state_d    = TAIL;
                                tail_cnt_d = TAIL_C;
                            end
                        end
                    end
                end
            end
            TAIL: begin
                if (dac_strobe) begin
                    dac_iq_d    = '0;
                    dac_valid_d = 1'b0;
                    tail_cnt_d  = tail_cnt_q - 1'b1;
                    if (tail_cnt_q == TAIL_W'(1)) begin
                        state_d   = IDLE;
                        tx_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        tx_active_d = (state_d != IDLE);
    end

    // State and registered outputs; reset discards the packet without tx_done
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            tail_cnt_q  <= '0;
            dac_iq_q    <= '0;
            dac_valid_q <= 1'b0;
            underflow_q <= 1'b0;
            ucnt_q      <= '0;
            tx_done_q   <= 1'b0;
            tx_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tail_cnt_q  <= tail_cnt_d;
            dac_iq_q    <= dac_iq_d;
            dac_valid_q <= dac_valid_d;
            underflow_q <= underflow_d;
            ucnt_q      <= ucnt_d;
            tx_done_q   <= tx_done_d;
            tx_active_q <= tx_active_d;
        end
    end

    assign dac_iq        = dac_iq_q;
    assign dac_valid     = dac_valid_q;
    assign underflow     = underflow_q;
    assign underflow_cnt = ucnt_q;
    assign tx_done       = tx_done_q;
    assign tx_active     = tx_active_q;

endmodule

// File: tb/tb_tx_iq_out_buffer.sv
// Directed bench for tx_iq_out_buffer. Instance A uses START_LEVEL=8,
// TAIL_LEN=16; instance B uses START_LEVEL=2, TAIL_LEN=0. 'sel' routes the
// shared stimulus to one instance and selects which outputs are observed.
module tb_tx_iq_out_buffer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sel;
    logic [15:0] in_i, in_q;
    logic        in_last, in_valid, dac_strobe;

    logic        in_ready_a, dac_valid_a, tx_active_a, underflow_a, tx_done_a;
    logic [31:0] dac_iq_a;
    logic [15:0] ucnt_a;
    logic        in_ready_b, dac_valid_b, tx_active_b, underflow_b, tx_done_b;
    logic [31:0] dac_iq_b;
    logic [15:0] ucnt_b;

    logic        in_valid_a, in_valid_b, strobe_a, strobe_b;
    logic        in_ready_m, dac_valid_m, tx_active_m, underflow_m, tx_done_m;
    logic [31:0] dac_iq_m;
    logic [15:0] ucnt_m;

    int n_total = 0;
    int n_bad   = 0;
    int acc;
    logic rdy;

    always #5 clk = ~clk;

    assign in_valid_a = in_valid & ~sel;
    assign in_valid_b = in_valid &  sel;
    assign strobe_a   = dac_strobe & ~sel;
    assign strobe_b   = dac_strobe &  sel;

    assign in_ready_m  = sel ? in_ready_b  : in_ready_a;
    assign dac_iq_m    = sel ? dac_iq_b    : dac_iq_a;
    assign dac_valid_m = sel ? dac_valid_b : dac_valid_a;
    assign tx_active_m = sel ? tx_active_b : tx_active_a;
    assign underflow_m = sel ? underflow_b : underflow_a;
    assign ucnt_m      = sel ? ucnt_b      : ucnt_a;
    assign tx_done_m   = sel ? tx_done_b   : tx_done_a;

    tx_iq_out_buffer #(.DEPTH_LOG2(4), .START_LEVEL(8), .TAIL_LEN(16)) u_dut_a (
        .clk(clk), .rstn(rstn), .in_i(in_i), .in_q(in_q), .in_last(in_last),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .dac_strobe(strobe_a),
        .dac_iq(dac_iq_a), .dac_valid(dac_valid_a), .tx_active(tx_active_a),
        .underflow(underflow_a), .underflow_cnt(ucnt_a), .tx_done(tx_done_a)
    );

    tx_iq_out_buffer #(.DEPTH_LOG2(4), .START_LEVEL(2), .TAIL_LEN(0)) u_dut_b (
        .clk(clk), .rstn(rstn), .in_i(in_i), .in_q(in_q), .in_last(in_last),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .dac_strobe(strobe_b),
        .dac_iq(dac_iq_b), .dac_valid(dac_valid_b), .tx_active(tx_active_b),
        .underflow(underflow_b), .underflow_cnt(ucnt_b), .tx_done(tx_done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    function automatic logic [31:0] pack(input int i, input int q);
        return {i[15:0], q[15:0]};
    endfunction

    task automatic push(input int i, input int q, input logic last);
        int guard = 0;
        while (!in_ready_m && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) check("push_ready_timeout", {31'b0, in_ready_m}, 32'd1);
        in_valid = 1'b1;
        in_i     = i[15:0];
        in_q     = q[15:0];
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // One strobe slot of four cycles: check the update, then the hold and pulse widths
    task automatic strobe(input string tag, input logic [31:0] exp_iq, input logic exp_v,
                          input logic exp_done, input logic exp_uf);
        dac_strobe = 1'b1;
        tick();
        dac_strobe = 1'b0;
        check({tag, "_iq"},   dac_iq_m,    exp_iq);
        check({tag, "_v"},    dac_valid_m, {31'b0, exp_v});
        check({tag, "_done"}, tx_done_m,   {31'b0, exp_done});
        check({tag, "_uf"},   underflow_m, {31'b0, exp_uf});
        tick();
        check({tag, "_hold"},  dac_iq_m, exp_done ? 32'h0 : exp_iq);
        check({tag, "_pulse"}, {30'b0, underflow_m, tx_done_m}, 32'd0);
        tick();
        tick();
    endtask

    task automatic tail(input string tag, input int n);
        for (int j = 0; j < n; j++) begin
            strobe($sformatf("%s%0d", tag, j), 32'h0, 1'b0, j == n - 1, 1'b0);
        end
    endtask

    task automatic settle();
        tick();
        tick();
        tick();
    endtask

    // Three-sample packet with last on the third, then the 16-zero tail
    task automatic short_packet(input string tag, input int base);
        for (int k = 0; k < 3; k++) push(base + k, base + 16'h0100 + k, k == 2);
        settle();
        for (int k = 0; k < 3; k++) begin
            strobe($sformatf("%s_s%0d", tag, k), pack(base + k, base + 16'h0100 + k), 1'b1, 1'b0, 1'b0);
        end
        tail({tag, "_t"}, 16);
        check({tag, "_active"}, tx_active_m, 32'd0);
    endtask

    initial begin
        rstn       = 1'b0;
        sel        = 1'b0;
        in_i       = '0;
        in_q       = '0;
        in_last    = 1'b0;
        in_valid   = 1'b0;
        dac_strobe = 1'b0;
        tick();
        tick();

        // Reset state, both instances
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check($sformatf("rst%0d_iq", s),     dac_iq_m,    32'd0);
            check($sformatf("rst%0d_v", s),      dac_valid_m, 32'd0);
            check($sformatf("rst%0d_ready", s),  in_ready_m,  32'd1);
            check($sformatf("rst%0d_active", s), tx_active_m, 32'd0);
            check($sformatf("rst%0d_ucnt", s),   ucnt_m,      32'd0);
            check($sformatf("rst%0d_done", s),   tx_done_m,   32'd0);
            check($sformatf("rst%0d_uf", s),     underflow_m, 32'd0);
        end
        sel = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        // Basic stream: I=k, Q=-k, last on k=9
        for (int k = 0; k < 10; k++) push(k, -k, k == 9);
        settle();
        check("b1_active", tx_active_m, 32'd1);
        for (int k = 0; k < 10; k++) strobe($sformatf("b1_s%0d", k), pack(k, -k), 1'b1, 1'b0, 1'b0);
        tail("b1_t", 16);
        check("b1_ucnt", ucnt_m, 32'd0);
        check("b1_idle", tx_active_m, 32'd0);

        // Short packet: PRIME must exit on the last flag below START_LEVEL
        short_packet("sp", 16'h0A00);

        // Underflow on instance B (START_LEVEL=2, TAIL_LEN=0)
        sel = 1'b1;
        tick();
        push(16'h0011, 16'h0022, 1'b0);
        push(16'h0033, 16'h0044, 1'b0);
        settle();
        strobe("uf_s0", 32'h0011_0022, 1'b1, 1'b0, 1'b0);
        strobe("uf_s1", 32'h0033_0044, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) strobe($sformatf("uf_z%0d", k), 32'h0, 1'b0, 1'b0, 1'b1);
        check("uf_cnt", ucnt_m, 32'd3);
        push(16'h0777, 16'h8888, 1'b1);
        settle();
        strobe("uf_last", 32'h0777_8888, 1'b1, 1'b1, 1'b0);
        check("uf_cnt_end", ucnt_m, 32'd3);
        check("uf_idle", tx_active_m, 32'd0);
        sel = 1'b0;
        tick();

        // Backpressure: no strobes, 20 attempted pushes, last on the 16th
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_i     = 16'(16'h1000 + acc);
            in_q     = 16'(16'h2000 + acc);
            in_last  = (acc == 15);
            rdy      = in_ready_m;
            tick();
            if (rdy) acc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_accepts", acc, 32'd16);
        check("bp_ready", in_ready_m, 32'd0);
        for (int k = 0; k < 16; k++) begin
            strobe($sformatf("bp_s%0d", k), pack(16'h1000 + k, 16'h2000 + k), 1'b1, 1'b0, 1'b0);
        end
        tail("bp_t", 16);
        check("bp_ready_end", in_ready_m, 32'd1);
        check("bp_idle", tx_active_m, 32'd0);

        // Back-to-back: packet A with two underflows, B queued during A's tail
        for (int k = 0; k < 8; k++) push(16'h3000 + k, 16'h3100 + k, 1'b0);
        settle();
        for (int k = 0; k < 8; k++) begin
            strobe($sformatf("bb_a%0d", k), pack(16'h3000 + k, 16'h3100 + k), 1'b1, 1'b0, 1'b0);
        end
        strobe("bb_u0", 32'h0, 1'b0, 1'b0, 1'b1);
        strobe("bb_u1", 32'h0, 1'b0, 1'b0, 1'b1);
        push(16'h30FF, 16'h31FF, 1'b1);
        settle();
        strobe("bb_alast", 32'h30FF_31FF, 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 16; j++) begin
            if (j == 4) begin
                for (int k = 0; k < 5; k++) push(16'h5000 + k, 16'h5100 + k, k == 4);
            end
            if (j == 15) begin
                dac_strobe = 1'b1;
                tick();
                dac_strobe = 1'b0;
                check("bb_t15_done", tx_done_m, 32'd1);
                check("bb_t15_v", dac_valid_m, 32'd0);
                check("bb_t15_ucnt", ucnt_m, 32'd2);
                tick();
                tick();
                check("bb_b_ucnt", ucnt_m, 32'd0);
                check("bb_b_active", tx_active_m, 32'd1);
                tick();
            end else begin
                strobe($sformatf("bb_t%0d", j), 32'h0, 1'b0, 1'b0, 1'b0);
            end
        end
        for (int k = 0; k < 5; k++) begin
            strobe($sformatf("bb_b%0d", k), pack(16'h5000 + k, 16'h5100 + k), 1'b1, 1'b0, 1'b0);
        end
        tail("bb_bt", 16);

        // Reset mid-STREAM after 4 of 10 samples
        for (int k = 0; k < 10; k++) push(16'h0700 + k, 16'h0800 + k, k == 9);
        settle();
        for (int k = 0; k < 4; k++) begin
            strobe($sformatf("rs_s%0d", k), pack(16'h0700 + k, 16'h0800 + k), 1'b1, 1'b0, 1'b0);
        end
        rstn = 1'b0;
        #2;
        check("rs_iq", dac_iq_m, 32'd0);
        check("rs_v", dac_valid_m, 32'd0);
        check("rs_active", tx_active_m, 32'd0);
        check("rs_ready", in_ready_m, 32'd1);
        check("rs_done", tx_done_m, 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("rs_post%0d", c), {30'b0, tx_done_m, tx_active_m}, 32'd0);
        end
        short_packet("rs_new", 16'h0C00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Absolute time bound so the run can never hang
    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tx_iq_out_buffer.md
# tx_iq_out_buffer

Output sample buffer that sits directly downstream of the per-rail amplitude scalers in the OFDM transmit path. It accepts scaled 16-bit I/Q sample pairs under a valid/ready handshake and stores them in a small FIFO. It releases one sample per DAC strobe as a packed 32-bit word, primes before streaming, zero-fills underflows and appends a configurable run of trailing zero samples after each packet.

## Interface
- DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 entries
- START_LEVEL, 8, FIFO occupancy required before streaming begins (1..2^DEPTH_LOG2)
- TAIL_LEN, 16, zero samples emitted after a packet's last sample (0..255)

Ports:
- clk  in  1  single clock for the whole block
- rstn  in  1  reset, asynchronous, active-low
- in_i  in  16  scaled I sample, two's complement
- in_q  in  16  scaled Q sample, two's complement
- in_last  in  1  marks the final sample of a packet
- in_valid  in  1  input sample present
- in_ready  out  1  block can accept a sample
- dac_strobe  in  1  one-cycle pulse per DAC sample slot
- dac_iq  out  32  {I[15:0], Q[15:0]} to the DAC interface
- dac_valid  out  1  dac_iq carries a packet sample (not fill or tail)
- tx_active  out  1  high in PRIME, STREAM and TAIL
- underflow  out  1  one-cycle pulse per zero-filled strobe in STREAM
- underflow_cnt  out  16  underflows in the current packet, saturating
- tx_done  out  1  one-cycle pulse at end of packet

## Operation
- FIFO entry = {i, q, last}, 33 bits. Push when in_valid && in_ready. in_ready = !full, computed from registered occupancy. When full, no push is allowed, even if a pop occurs in the same cycle.
- Input is accepted in every state. Samples of the next packet queue up during STREAM and TAIL.
- States:
  - IDLE: dac_iq = 0. Leave to PRIME when occupancy becomes non-zero. On that transition, underflow_cnt clears.
  - PRIME: no pops. Go to STREAM when occupancy >= START_LEVEL, or when any stored entry has last = 1. Track this with a count of last-marked entries in the FIFO.
  - STREAM: each dac_strobe pops one entry, loads dac_iq and asserts dac_valid.
    - If the FIFO is empty at the strobe: dac_iq = 0, dac_valid = 0, underflow pulses, underflow_cnt increments and saturates at 0xFFFF.
    - If the popped entry has last = 1: go to TAIL with tail counter = TAIL_LEN. If TAIL_LEN = 0, go to IDLE and pulse tx_done instead.
  - TAIL: each strobe outputs dac_iq = 0 with dac_valid = 0 and decrements the counter. The strobe that emits the final zero pulses tx_done and returns to IDLE.
- No arithmetic is applied to samples. I and Q pass through bit-exact.
- Reset mid-packet: all state and FIFO contents are discarded immediately, with no tx_done.

## Timing
- All outputs are registered. dac_iq, dac_valid and underflow update in the cycle after the strobe. dac_iq holds its value between strobes.
- tx_done pulses in the same cycle as the dac_iq update for the last tail zero. If TAIL_LEN = 0, it coincides with the last sample.
- Input-to-FIFO latency is 1 cycle. A sample pushed at cycle n can be popped by a strobe at cycle n+1.
- Simultaneous push and pop (not full): occupancy is unchanged.
- Strobe in IDLE or PRIME: no pop, dac_iq = 0, no underflow counted.
- Reset values:
  - dac_iq = 0, dac_valid = 0
  - underflow = 0, underflow_cnt = 0
  - tx_done = 0, tx_active = 0
  - in_ready = 1 (registered, so it reads 1 during reset)
  - state = IDLE, occupancy = 0

## Structure
- Package tx_iq_pkg holds:
  - IQ_W = 16
  - state enum {IDLE, PRIME, STREAM, TAIL}
  - packed struct iq_entry_t {i, q, last}
- One sub-module, tx_iq_fifo: synchronous FIFO of iq_entry_t with full, empty, occupancy and last-entry count. The parent module holds the FSM, tail counter and output registers.

## Test plan
- Basic stream: push 10 samples (I = k, Q = -k, last on k = 9), strobe every 4 cycles, TAIL_LEN = 16, START_LEVEL = 8.
  - Required: dac_iq = {k, -k} for k = 0..9 with dac_valid high, then 16 zeros with dac_valid low.
  - tx_done pulses with the 16th zero; underflow_cnt = 0.
- Short packet: push 3 samples with last on the third. PRIME must exit on the last flag.
  - Required: 3 valid outputs, then the tail.
- Underflow: START_LEVEL = 2, push 2 samples, strobe 5 times, then push 1 sample with last.
  - Required: 3 zero-filled strobes, underflow pulsed 3 times, underflow_cnt = 3, then the last sample is output.
- Backpressure: hold strobe low and push 20 samples.
  - Required: in_ready falls after 16 accepts; no overwrite; order preserved when draining.
- Back-to-back packets: queue packet B (5 samples) during packet A's tail.
  - Required: B starts only after A's tx_done.
  - underflow_cnt resets to 0 at B's PRIME entry.
- Reset mid-STREAM: assert rstn = 0 after 4 of 10 samples are output.
  - Required: all outputs go to 0 asynchronously; in_ready = 1; no tx_done.
  - A fresh packet afterwards streams normally.
